// File: rtl/can_frame_field_tracker_pkg.sv
// ---------------------------------------------------------------------------
// can_frame_pkg
// Shared definitions for the CAN frame field tracker:
//   - field_e        : 4-bit encoding of the field the next sampled bit is in
//   - LEN_*          : field lengths in bits
//   - CNT_W          : width of the per-field bit counter
//   - dlc_to_bits()  : DLC -> number of data bits, clamped to a byte cap
// Optional feature macro: CAN_EXT_ID_EN adds the extended-ID fields
// (ID_B, RTR_EXT, R1) to the encoding.
// ---------------------------------------------------------------------------
package can_frame_pkg;

  localparam int CNT_W = 7;

  typedef enum logic [3:0] {
    FLD_IDLE     = 4'd0,
    FLD_ID_A     = 4'd1,
    FLD_BIT12    = 4'd2,
    FLD_IDE      = 4'd3,
    FLD_R0       = 4'd4,
    FLD_DLC      = 4'd5,
    FLD_DATA     = 4'd6,
    FLD_CRC      = 4'd7,
    FLD_CRC_DEL  = 4'd8,
    FLD_ACK_SLOT = 4'd9,
    FLD_ACK_DEL  = 4'd10,
    FLD_EOF      = 4'd11,
    FLD_IFS      = 4'd12
`ifdef CAN_EXT_ID_EN
    ,
    FLD_ID_B     = 4'd13,
    FLD_RTR_EXT  = 4'd14,
    FLD_R1       = 4'd15
`endif
  } field_e;

  localparam int unsigned LEN_ID_A = 11;
  localparam int unsigned LEN_ID_B = 18;
  localparam int unsigned LEN_DLC  = 4;
  localparam int unsigned LEN_CRC  = 15;

  // Data field length in bits: 8 * min(dlc, max_bytes).
  function automatic logic [CNT_W-1:0] dlc_to_bits(input logic [3:0] dlc,
                                                   input int unsigned max_bytes);
    int unsigned bytes_v;
    bytes_v = (32'(dlc) > max_bytes) ? max_bytes : 32'(dlc);
    return CNT_W'(bytes_v * 32'd8);
  endfunction

endpackage

// File: rtl/can_frame_field_tracker_if.sv
// ---------------------------------------------------------------------------
// can_frame_field_tracker_if
// Bus bundle between the destuff/bit-timing stage (master) and the field
// tracker (slave).
//   master -> slave : SP, RX, STUFF_BIT, ABORT
//   slave -> master : FIELD, F_CRC_D, F_ACK_S, F_ACK_D, F_EOF, STUFF_EN,
//                     DLC, RTR, FRAME_DONE
// Strobe semantics: a bit is consumed on a clk edge where SP=1 and
// STUFF_BIT=0; SP is one clk wide and there is no back-pressure. ABORT acts
// on any clk edge regardless of SP.
// ---------------------------------------------------------------------------
interface can_frame_field_tracker_if;
  import can_frame_pkg::*;

  logic       SP;
  logic       RX;
  logic       STUFF_BIT;
  logic       ABORT;
  field_e     FIELD;
  logic       F_CRC_D;
  logic       F_ACK_S;
  logic       F_ACK_D;
  logic       F_EOF;
  logic       STUFF_EN;
  logic [3:0] DLC;
  logic       RTR;
  logic       FRAME_DONE;

  modport master (
    output SP, RX, STUFF_BIT, ABORT,
    input  FIELD, F_CRC_D, F_ACK_S, F_ACK_D, F_EOF, STUFF_EN, DLC, RTR, FRAME_DONE
  );

  modport slave (
    input  SP, RX, STUFF_BIT, ABORT,
    output FIELD, F_CRC_D, F_ACK_S, F_ACK_D, F_EOF, STUFF_EN, DLC, RTR, FRAME_DONE
  );
endinterface

// File: rtl/can_frame_field_tracker_counter.sv
// ---------------------------------------------------------------------------
// can_field_counter
// Loadable down-counter holding the remaining bits of the current field.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (count -> 0)
//   i_load       : load i_load_val (wins over i_en)
//   i_load_val   : field length minus 1
//   i_en         : qualified sample point; decrements while non-zero
//   o_zero       : count is zero (last bit of the field is next)
// ---------------------------------------------------------------------------
module can_field_counter
  import can_frame_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/can_frame_field_tracker.sv
// ---------------------------------------------------------------------------
// can_frame_field_tracker
// Follows a CAN frame on the destuffed RX stream, one bit per qualified
// sample point, and publishes which field the next sampled bit belongs to.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : can_frame_field_tracker_if.slave (SP/RX/STUFF_BIT/ABORT in;
//                FIELD, position flags, DLC, RTR, FRAME_DONE out)
// Parameters: EOF_BITS, IFS_BITS, MAX_DATA_BYTES.
// Optional feature macro: CAN_EXT_ID_EN (extended 29-bit identifier fields).
// FIELD is the FSM state itself, so it doubles as the debug view.
// ---------------------------------------------------------------------------
module can_frame_field_tracker
  import can_frame_pkg::*;
#(
  parameter int unsigned EOF_BITS       = 7,
  parameter int unsigned IFS_BITS       = 3,
  parameter int unsigned MAX_DATA_BYTES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  can_frame_field_tracker_if.slave  bus
);

  field_e           r_field;
  field_e           w_field_nxt;
  logic [3:0]       r_dlc;
  logic             r_rtr;
  logic             w_adv;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_cnt_zero;
  logic             w_done;
  logic             w_rtr_cap;
  logic             w_stuff_en;
  logic [3:0]       w_dlc_full;
  logic [CNT_W-1:0] w_data_bits;

  assign w_adv = bus.SP && !bus.STUFF_BIT;

  // DLC including the bit being sampled now; used when leaving the DLC field.
  assign w_dlc_full  = {r_dlc[2:0], bus.RX};
  assign w_data_bits = dlc_to_bits(w_dlc_full, MAX_DATA_BYTES);

`ifdef CAN_EXT_ID_EN
  // In an extended frame BIT12 is SRR; the real RTR overwrites it later.
  assign w_rtr_cap = (r_field == FLD_BIT12) || (r_field == FLD_RTR_EXT);
`else
  assign w_rtr_cap = (r_field == FLD_BIT12);
`endif

  can_field_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_adv),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_field <= FLD_IDLE;
    end else begin
      r_field <= w_field_nxt;
    end
  end

  // Next field / counter reload. Single-bit fields reload 0 (the default).
  always_comb begin
    w_field_nxt = r_field;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_done      = 1'b0;
    if (bus.ABORT) begin
      w_field_nxt = FLD_IDLE;
      w_load      = 1'b1;
    end else if (w_adv) begin
      if (r_field == FLD_IDLE) begin
        if (!bus.RX) begin
          w_field_nxt = FLD_ID_A;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(LEN_ID_A - 1);
        end
      end else if (w_cnt_zero) begin
        w_load = 1'b1;
        case (r_field)
          FLD_ID_A:  w_field_nxt = FLD_BIT12;
          FLD_BIT12: w_field_nxt = FLD_IDE;
          FLD_IDE: begin
            if (bus.RX) begin
`ifdef CAN_EXT_ID_EN
              w_field_nxt = FLD_ID_B;
              w_load_val  = CNT_W'(LEN_ID_B - 1);
`else
              // Extended frames are not tracked: drop back to IDLE.
              w_field_nxt = FLD_IDLE;
`endif
            end else begin
              w_field_nxt = FLD_R0;
            end
          end
`ifdef CAN_EXT_ID_EN
          FLD_ID_B:    w_field_nxt = FLD_RTR_EXT;
          FLD_RTR_EXT: w_field_nxt = FLD_R1;
          FLD_R1:      w_field_nxt = FLD_R0;
`endif
          FLD_R0: begin
            w_field_nxt = FLD_DLC;
            w_load_val  = CNT_W'(LEN_DLC - 1);
          end
          FLD_DLC: begin
            // Remote frames and zero-length frames carry no data field.
            if (r_rtr || (w_data_bits == '0)) begin
              w_field_nxt = FLD_CRC;
              w_load_val  = CNT_W'(LEN_CRC - 1);
            end else begin
              w_field_nxt = FLD_DATA;
              w_load_val  = w_data_bits - CNT_W'(1);
            end
          end
          FLD_DATA: begin
            w_field_nxt = FLD_CRC;
            w_load_val  = CNT_W'(LEN_CRC - 1);
          end
          FLD_CRC:      w_field_nxt = FLD_CRC_DEL;
          FLD_CRC_DEL:  w_field_nxt = FLD_ACK_SLOT;
          FLD_ACK_SLOT: w_field_nxt = FLD_ACK_DEL;
          FLD_ACK_DEL: begin
            w_field_nxt = FLD_EOF;
            w_load_val  = CNT_W'(EOF_BITS - 1);
          end
          FLD_EOF: begin
            w_field_nxt = FLD_IFS;
            w_load_val  = CNT_W'(IFS_BITS - 1);
            w_done      = 1'b1;
          end
          // RX is not looked at in IFS: a dominant bit there does not restart.
          FLD_IFS: w_field_nxt = FLD_IDLE;
          default: w_field_nxt = FLD_IDLE;
        endcase
      end
    end
  end

  // Captured frame header fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dlc <= '0;
      r_rtr <= 1'b0;
    end else if (!bus.ABORT && w_adv) begin
      if (r_field == FLD_DLC) begin
        r_dlc <= w_dlc_full;
      end
      if (w_rtr_cap) begin
        r_rtr <= bus.RX;
      end
    end
  end

  // Stuffing window: every field from the first ID bit through the last CRC bit.
  always_comb begin
    w_stuff_en = 1'b0;
    case (r_field)
      FLD_ID_A, FLD_BIT12, FLD_IDE, FLD_R0, FLD_DLC, FLD_DATA, FLD_CRC: w_stuff_en = 1'b1;
`ifdef CAN_EXT_ID_EN
      FLD_ID_B, FLD_RTR_EXT, FLD_R1: w_stuff_en = 1'b1;
`endif
      default: w_stuff_en = 1'b0;
    endcase
  end

  assign bus.FIELD      = r_field;
  assign bus.F_CRC_D    = (r_field == FLD_CRC_DEL);
  assign bus.F_ACK_S    = (r_field == FLD_ACK_SLOT);
  assign bus.F_ACK_D    = (r_field == FLD_ACK_DEL);
  assign bus.F_EOF      = (r_field == FLD_EOF);
  assign bus.STUFF_EN   = w_stuff_en;
  assign bus.DLC        = r_dlc;
  assign bus.RTR        = r_rtr;
  assign bus.FRAME_DONE = w_done && !reset;

endmodule

// File: tb/tb_can_frame_field_tracker.sv
// ---------------------------------------------------------------------------
// tb_can_frame_field_tracker
// Directed bench for can_frame_field_tracker. Frames are described in a
// table, expanded to a bit stream, and the field/flag outputs are compared
// at hand-computed sample-point indices. FRAME_DONE positions go through an
// expected queue. Abort/reset corner cases are hand-written sequences.
// Build with +define+CAN_EXT_ID_EN to exercise the extended-ID variant.
// ---------------------------------------------------------------------------
module tb_can_frame_field_tracker;
  import can_frame_pkg::*;

`ifdef CAN_EXT_ID_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  // flag vector order: {F_CRC_D, F_ACK_S, F_ACK_D, F_EOF, STUFF_EN}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] SE = 5'b00001;
  localparam logic [4:0] CD = 5'b10000;
  localparam logic [4:0] AS = 5'b01000;
  localparam logic [4:0] AD = 5'b00100;
  localparam logic [4:0] EO = 5'b00010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  can_frame_field_tracker_if bus ();

  can_frame_field_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {logic rx; logic st;} sp_t;
  sp_t bits_q[$];
  int  stuff_at;

  logic [6:0] exp_q[$];  // expected SP index of FRAME_DONE

  typedef struct {
    logic [10:0] id_a;
    logic [17:0] id_b;
    logic        rtr;
    logic        ide;
    logic [3:0]  dlc;
    int          stuff_at;
    int          ifs_dom;
    int          exp_done;
    logic [3:0]  exp_dlc;
    logic        exp_rtr;
  } frame_t;

  typedef struct {
    int         frm;
    int         sp_idx;
    logic [3:0] fld;
    logic [4:0] flg;
  } cp_t;

  frame_t frames[6];
  cp_t    cps[$];

  function automatic logic [4:0] flags_now();
    return {bus.F_CRC_D, bus.F_ACK_S, bus.F_ACK_D, bus.F_EOF, bus.STUFF_EN};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_cp(input int f, input int i, input logic [3:0] fld, input logic [4:0] flg);
    cp_t c;
    c.frm = f; c.sp_idx = i; c.fld = fld; c.flg = flg;
    cps.push_back(c);
  endtask

  // ---------------- driver ----------------
  task automatic send_sp(input logic rx, input logic st, output logic done);
    @(negedge clk);
    bus.SP = 1'b1; bus.RX = rx; bus.STUFF_BIT = st;
    #1 done = bus.FRAME_DONE;
    @(posedge clk);
    #1;
    bus.SP = 1'b0; bus.STUFF_BIT = 1'b0; bus.RX = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bit(input logic rx);
    sp_t s;
    if (bits_q.size() == stuff_at) begin
      s.rx = 1'b1; s.st = 1'b1;
      bits_q.push_back(s);
    end
    s.rx = rx; s.st = 1'b0;
    bits_q.push_back(s);
  endtask

  task automatic build_frame(input frame_t f);
    int         ndata;
    logic [7:0] byt;
    logic [14:0] crc_v;
    crc_v = 15'h4A5C;
    bits_q.delete();
    stuff_at = f.stuff_at;
    push_bit(1'b0);                                  // SOF
    for (int i = 10; i >= 0; i--) push_bit(f.id_a[i]);
    if (f.ide) begin
      push_bit(1'b1);                                // SRR
      push_bit(1'b1);                                // IDE
      if (!EXT) begin
        for (int i = 0; i < 3; i++) push_bit(1'b1);
        return;
      end
      for (int i = 17; i >= 0; i--) push_bit(f.id_b[i]);
      push_bit(f.rtr);
      push_bit(1'b0);                                // R1
      push_bit(1'b0);                                // R0
    end else begin
      push_bit(f.rtr);
      push_bit(1'b0);                                // IDE
      push_bit(1'b0);                                // R0
    end
    for (int i = 3; i >= 0; i--) push_bit(f.dlc[i]);
    ndata = f.rtr ? 0 : ((f.dlc > 4'd8) ? 8 : int'(f.dlc)) * 8;
    for (int b = 0; b < ndata; b++) begin
      byt = ((b / 8) % 2 == 0) ? 8'hAA : 8'h55;
      push_bit(byt[7 - (b % 8)]);
    end
    for (int i = 14; i >= 0; i--) push_bit(crc_v[i]);
    push_bit(1'b1);                                  // CRC delimiter
    push_bit(1'b0);                                  // ACK slot
    push_bit(1'b1);                                  // ACK delimiter
    for (int i = 0; i < 7; i++) push_bit(1'b1);      // EOF
    for (int i = 0; i < 3; i++) push_bit((bits_q.size() == f.ifs_dom) ? 1'b0 : 1'b1);
    push_bit(1'b1);                                  // bus idle
    push_bit(1'b1);
  endtask

  // ---------------- scoreboard-driven frame run ----------------
  task automatic run_frame(input int k);
    logic       done;
    logic [6:0] exp_idx;
    build_frame(frames[k]);
    if (frames[k].exp_done >= 0) exp_q.push_back(7'(frames[k].exp_done));
    for (int i = 0; i < bits_q.size(); i++) begin
      send_sp(bits_q[i].rx, bits_q[i].st, done);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL f%0d unexpected FRAME_DONE: got pulse at sp %0d required none", k, i);
        end else begin
          exp_idx = exp_q.pop_front();
          check($sformatf("f%0d FRAME_DONE position", k), 32'(i), 32'(exp_idx));
        end
      end
      foreach (cps[c]) begin
        if (cps[c].frm == k && cps[c].sp_idx == i) begin
          check($sformatf("f%0d sp%0d FIELD", k, i), 32'(bus.FIELD), 32'(cps[c].fld));
          check($sformatf("f%0d sp%0d flags", k, i), 32'(flags_now()), 32'(cps[c].flg));
        end
      end
    end
    check($sformatf("f%0d missing FRAME_DONE count", k), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check($sformatf("f%0d DLC", k), 32'(bus.DLC), 32'(frames[k].exp_dlc));
    check($sformatf("f%0d RTR", k), 32'(bus.RTR), 32'(frames[k].exp_rtr));
  endtask

  // ---------------- main ----------------
  initial begin : main
    logic done;

    // Frame table: id_a, id_b, rtr, ide, dlc, stuff_at, ifs_dom, exp_done, exp_dlc, exp_rtr
    frames[0] = '{11'h123, 18'h0, 1'b0, 1'b0, 4'd2,  -1, -1, 59,  4'd2,  1'b0};
    frames[1] = '{11'h2A5, 18'h0, 1'b1, 1'b0, 4'd5,  -1, -1, 43,  4'd5,  1'b1};
    frames[2] = '{11'h7F0, 18'h0, 1'b0, 1'b0, 4'd15, -1, -1, 107, 4'd15, 1'b0};
    frames[3] = '{11'h00F, 18'h0, 1'b0, 1'b0, 4'd2,   5, -1, 60,  4'd2,  1'b0};
    frames[4] = '{11'h123, 18'h0, 1'b0, 1'b0, 4'd2,  -1, 61, 59,  4'd2,  1'b0};
`ifdef CAN_EXT_ID_EN
    frames[5] = '{11'h555, 18'h2AB3C, 1'b0, 1'b1, 4'd1, -1, -1, 71, 4'd1, 1'b0};
`else
    frames[5] = '{11'h555, 18'h2AB3C, 1'b0, 1'b1, 4'd1, -1, -1, -1, 4'd2, 1'b1};
`endif

    // Checkpoints: FIELD/flags after the SP with the given index.
    add_cp(0, 0, FLD_ID_A, SE);      add_cp(0, 11, FLD_BIT12, SE);
    add_cp(0, 12, FLD_IDE, SE);      add_cp(0, 13, FLD_R0, SE);
    add_cp(0, 14, FLD_DLC, SE);      add_cp(0, 18, FLD_DATA, SE);
    add_cp(0, 33, FLD_DATA, SE);     add_cp(0, 34, FLD_CRC, SE);
    add_cp(0, 48, FLD_CRC, SE);      add_cp(0, 49, FLD_CRC_DEL, CD);
    add_cp(0, 50, FLD_ACK_SLOT, AS); add_cp(0, 51, FLD_ACK_DEL, AD);
    add_cp(0, 52, FLD_EOF, EO);      add_cp(0, 58, FLD_EOF, EO);
    add_cp(0, 59, FLD_IFS, NO);      add_cp(0, 61, FLD_IFS, NO);
    add_cp(0, 62, FLD_IDLE, NO);
    add_cp(1, 18, FLD_CRC, SE);      add_cp(1, 33, FLD_CRC_DEL, CD);
    add_cp(1, 45, FLD_IFS, NO);      add_cp(1, 46, FLD_IDLE, NO);
    add_cp(2, 81, FLD_DATA, SE);     add_cp(2, 82, FLD_CRC, SE);
    add_cp(2, 97, FLD_CRC_DEL, CD);  add_cp(2, 110, FLD_IDLE, NO);
    add_cp(3, 4, FLD_ID_A, SE);      add_cp(3, 5, FLD_ID_A, SE);
    add_cp(3, 11, FLD_ID_A, SE);     add_cp(3, 12, FLD_BIT12, SE);
    add_cp(3, 49, FLD_CRC, SE);      add_cp(3, 50, FLD_CRC_DEL, CD);
    add_cp(3, 63, FLD_IDLE, NO);
    add_cp(4, 60, FLD_IFS, NO);      add_cp(4, 61, FLD_IFS, NO);
    add_cp(4, 62, FLD_IDLE, NO);
`ifdef CAN_EXT_ID_EN
    add_cp(5, 13, FLD_ID_B, SE);     add_cp(5, 30, FLD_ID_B, SE);
    add_cp(5, 31, FLD_RTR_EXT, SE);  add_cp(5, 32, FLD_R1, SE);
    add_cp(5, 33, FLD_R0, SE);       add_cp(5, 34, FLD_DLC, SE);
    add_cp(5, 38, FLD_DATA, SE);     add_cp(5, 46, FLD_CRC, SE);
    add_cp(5, 61, FLD_CRC_DEL, CD);  add_cp(5, 74, FLD_IDLE, NO);
`else
    add_cp(5, 12, FLD_IDE, SE);      add_cp(5, 13, FLD_IDLE, NO);
    add_cp(5, 16, FLD_IDLE, NO);
`endif

    // Reset
    bus.SP = 1'b0; bus.RX = 1'b1; bus.STUFF_BIT = 1'b0; bus.ABORT = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset FIELD", 32'(bus.FIELD), 32'(FLD_IDLE));
    check("reset flags", 32'(flags_now()), 32'(NO));
    check("reset DLC", 32'(bus.DLC), 32'd0);
    check("reset RTR", 32'(bus.RTR), 32'd0);
    check("reset FRAME_DONE", 32'(bus.FRAME_DONE), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Recessive SP in IDLE, and a dominant stuff-flagged SP: neither starts a frame.
    send_sp(1'b1, 1'b0, done);
    check("idle recessive FIELD", 32'(bus.FIELD), 32'(FLD_IDLE));
    send_sp(1'b0, 1'b1, done);
    check("idle stuff-bit FIELD", 32'(bus.FIELD), 32'(FLD_IDLE));

    for (int k = 0; k < 6; k++) run_frame(k);

    // ABORT during DATA, then a new SOF is accepted.
    build_frame(frames[0]);
    for (int i = 0; i < 26; i++) send_sp(bits_q[i].rx, bits_q[i].st, done);
    check("pre-abort FIELD", 32'(bus.FIELD), 32'(FLD_DATA));
    @(negedge clk);
    bus.ABORT = 1'b1;
    @(posedge clk);
    #1;
    bus.ABORT = 1'b0;
    check("abort FIELD", 32'(bus.FIELD), 32'(FLD_IDLE));
    check("abort flags", 32'(flags_now()), 32'(NO));
    send_sp(1'b0, 1'b0, done);
    check("post-abort SOF FIELD", 32'(bus.FIELD), 32'(FLD_ID_A));
    check("post-abort SOF flags", 32'(flags_now()), 32'(SE));

    // ABORT wins over a simultaneous SP.
    @(negedge clk);
    bus.ABORT = 1'b1; bus.SP = 1'b1; bus.RX = 1'b0;
    @(posedge clk);
    #1;
    bus.ABORT = 1'b0; bus.SP = 1'b0; bus.RX = 1'b1;
    check("abort+SP FIELD", 32'(bus.FIELD), 32'(FLD_IDLE));

    // Reset wins over ABORT and clears the captured header.
    send_sp(1'b0, 1'b0, done);
    check("restart FIELD", 32'(bus.FIELD), 32'(FLD_ID_A));
    @(negedge clk);
    reset = 1'b1; bus.ABORT = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; bus.ABORT = 1'b0;
    check("reset+abort FIELD", 32'(bus.FIELD), 32'(FLD_IDLE));
    check("reset+abort DLC", 32'(bus.DLC), 32'd0);
    check("reset+abort RTR", 32'(bus.RTR), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
